// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver (configurable data/parity/stop) feeding a valid/ready FIFO.
// Optional break detection is compiled in with `define UART_RX_FIFO_BREAK_DETECT_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic                        rx_line,
  output logic [8:0]                  m_data,
  output logic                        m_perr,
  output logic                        m_ferr,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_busy,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic                        rx_break
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           r_state, w_next;
  logic             r_sync1, r_sync2, r_rxs_d;
  logic [DIV_W-1:0] r_div, r_pre, w_div_m1;
  logic [3:0]       r_os;
  logic             r_s7, r_s8;
  logic [3:0]       r_bit;
  logic             r_stop;
  logic [8:0]       r_data;
  logic             r_perr, r_ferr;
  logic             w_fall, w_tick, w_vote, w_vote_ev, w_end_ev;
  logic             w_start, w_push, w_ferr_fin;
  logic [10:0]      w_word;

  // Input synchroniser and edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx_line;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  assign w_fall   = r_rxs_d & ~r_sync2;
  assign w_div_m1 = (r_div == '0) ? '0 : r_div - 1'b1;
  assign w_tick   = (r_pre == w_div_m1);

  // Prescaler and oversample counter; a new divisor is picked up only at a wrap or a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_div <= '0;
      r_os  <= '0;
    end else if (w_start) begin
      r_pre <= '0;
      r_div <= baud_div;
      r_os  <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_div <= baud_div;
      r_os  <= r_os + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_vote     = majority3(r_s7, r_s8, r_sync2);
  assign w_vote_ev  = w_tick && (r_os == 4'd9);
  assign w_end_ev   = w_tick && (r_os == 4'd15);
  assign w_ferr_fin = r_ferr | ~w_vote;
  assign w_word     = {r_perr, w_ferr_fin, r_data};

`ifdef UART_RX_FIFO_BREAK_DETECT_EN
  logic r_par, r_brk, w_brk;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_push  = 1'b0;
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
    w_brk   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_start = 1'b1;
          w_next  = S_START;
        end
      end
      S_START: begin
        if (w_vote_ev && w_vote) w_next = S_IDLE;
        else if (w_end_ev)       w_next = S_DATA;
      end
      S_DATA: begin
        if (w_end_ev && (r_bit == LAST_BIT))
          w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_end_ev) w_next = S_STOP;
      end
      S_STOP: begin
        // Leave mid-bit so the next start edge can be caught early
        if (w_vote_ev && (r_stop == LAST_STOP)) begin
          w_push = 1'b1;
          w_next = S_IDLE;
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
          if (w_ferr_fin && (r_data == '0) && !r_par) begin
            w_brk  = 1'b1;
            w_next = S_BREAK;
          end
`endif
        end
      end
      S_BREAK: begin
        if (r_sync2) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame datapath: vote sampling, data shift-in, parity and framing flags
  always_ff @(posedge clk) begin
    if (w_tick && (r_os == 4'd7)) r_s7 <= r_sync2;
    if (w_tick && (r_os == 4'd8)) r_s8 <= r_sync2;
    if (w_start) begin
      r_data <= '0;
      r_bit  <= '0;
      r_stop <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      case (r_state)
        S_DATA: begin
          if (w_vote_ev) r_data[r_bit] <= w_vote;
          if (w_end_ev)  r_bit <= r_bit + 1'b1;
        end
        S_PARITY: begin
          if (w_vote_ev) r_perr <= ((^r_data) ^ w_vote) != (PARITY == 1);
        end
        S_STOP: begin
          if (w_vote_ev) r_ferr <= w_ferr_fin;
          if (w_end_ev)  r_stop <= r_stop + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_FIFO_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (w_start)                            r_par <= 1'b0;
    else if (r_state == S_PARITY && w_vote_ev) r_par <= w_vote;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_brk <= 1'b0;
    else       r_brk <= w_brk;
  end

  assign rx_break = r_brk;
`else
  assign rx_break = 1'b0;
`endif

  assign rx_busy = (r_state != S_IDLE);

  // Receive FIFO
  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_ovr;
  logic          w_full, w_pop, w_wr_en;
  logic [10:0]   w_head;

  assign w_full  = (r_cnt == DEPTH_C);
  assign m_valid = (r_cnt != '0);
  assign w_pop   = m_valid & m_ready;
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (w_push && w_full && !w_pop) r_ovr <= 1'b1;
      else if (ovr_clr)               r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= w_word;
  end

  assign w_head     = r_mem[r_rd];
  assign m_data     = m_valid ? w_head[8:0] : 9'd0;
  assign m_ferr     = m_valid & w_head[9];
  assign m_perr     = m_valid & w_head[10];
  assign fifo_count = r_cnt;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 instance (A) and 9-bit/even-parity/2-stop depth-4 instance (B).
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rx_a, rx_b, rdy_a, rdy_b, clr_a, clr_b;
  logic [15:0] baud_div;
  logic [8:0]  data_a, data_b;
  logic        perr_a, perr_b, ferr_a, ferr_b, vld_a, vld_b;
  logic        busy_a, busy_b, ovr_a, ovr_b, brk_a, brk_b;
  logic [3:0]  cnt_a;
  logic [2:0]  cnt_b;
  int          checks = 0, failures = 0, div_cur = 27, brk_seen = 0;
  int          exp_brk;

  assign baud_div = 16'(div_cur);

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_W(16)) u_a (
    .clk(clk), .reset(reset), .baud_div(baud_div), .rx_line(rx_a),
    .m_data(data_a), .m_perr(perr_a), .m_ferr(ferr_a), .m_valid(vld_a), .m_ready(rdy_a),
    .fifo_count(cnt_a), .rx_busy(busy_a), .overrun(ovr_a), .ovr_clr(clr_a), .rx_break(brk_a));

  uart_rx_fifo #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) u_b (
    .clk(clk), .reset(reset), .baud_div(baud_div), .rx_line(rx_b),
    .m_data(data_b), .m_perr(perr_b), .m_ferr(ferr_b), .m_valid(vld_b), .m_ready(rdy_b),
    .fifo_count(cnt_b), .rx_busy(busy_b), .overrun(ovr_b), .ovr_clr(clr_b), .rx_break(brk_b));

  always @(posedge clk) if (brk_a) brk_seen <= brk_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) rx_b = bits[i]; else rx_a = bits[i];
      repeat (16 * div_cur) @(posedge clk);
      #1;
    end
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    repeat (32) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input bit sel, input string tag, input logic [8:0] d,
                           input logic pe, input logic fe);
    if (sel) begin
      check({tag, "_vld"},  32'(vld_b),  32'd1);
      check({tag, "_data"}, 32'(data_b), 32'(d));
      check({tag, "_perr"}, 32'(perr_b), 32'(pe));
      check({tag, "_ferr"}, 32'(ferr_b), 32'(fe));
      rdy_b = 1'b1;
    end else begin
      check({tag, "_vld"},  32'(vld_a),  32'd1);
      check({tag, "_data"}, 32'(data_a), 32'(d));
      check({tag, "_perr"}, 32'(perr_a), 32'(pe));
      check({tag, "_ferr"}, 32'(ferr_a), 32'(fe));
      rdy_a = 1'b1;
    end
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  logic [8:0] vals [5];

  initial begin
    vals = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld_a",  32'(vld_a),  32'd0);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_cnt_a",  32'(cnt_a),  32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ovr_a",  32'(ovr_a),  32'd0);
    check("rst_brk_a",  32'(brk_a),  32'd0);
    check("rst_vld_b",  32'(vld_b),  32'd0);
    check("rst_cnt_b",  32'(cnt_b),  32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // T1: 8N1 0xA5 at divisor 27; stop vote lands 3 + 154*27 clocks after the start edge
    fork
      send(1'b0, {1'b1, 8'hA5, 1'b0}, 10);
      begin
        repeat (2 + 154 * 27) @(posedge clk);
        #1;
        check("t1_vld_before", 32'(vld_a), 32'd0);
        @(posedge clk);
        #1;
        check("t1_vld_after", 32'(vld_a), 32'd1);
      end
    join
    check("t1_cnt", 32'(cnt_a), 32'd1);
    pop_check(1'b0, "t1", 9'h0A5, 1'b0, 1'b0);
    check("t1_empty", 32'(vld_a), 32'd0);

    div_cur = 4;
    repeat (4) @(posedge clk);
    #1;

    // T2: even parity, 0x03C has four ones; parity bit 1 is wrong, 0 is right
    send(1'b1, {3'b111, 9'h03C, 1'b0}, 13);
    check("t2_cnt", 32'(cnt_b), 32'd1);
    pop_check(1'b1, "t2_bad", 9'h03C, 1'b1, 1'b0);
    send(1'b1, {3'b110, 9'h03C, 1'b0}, 13);
    pop_check(1'b1, "t2_good", 9'h03C, 1'b0, 1'b0);

    // T3: 0x1FF, correct parity 1, second stop bit low
    send(1'b1, {3'b011, 9'h1FF, 1'b0}, 13);
    pop_check(1'b1, "t3", 9'h1FF, 1'b0, 1'b1);

    // T4: 16-clock (4-tick) low glitch is a false start, busy drops at the START os_cnt 9 tick
    rx_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (26) @(posedge clk);
    #1;
    check("t4_busy_hi", 32'(busy_a), 32'd1);
    @(posedge clk);
    #1;
    check("t4_busy_lo", 32'(busy_a), 32'd0);
    repeat (64) @(posedge clk);
    #1;
    check("t4_cnt", 32'(cnt_a), 32'd0);

    // T5: depth-4 FIFO, five words with no consumer
    for (int i = 0; i < 5; i++) send(1'b1, {3'b110, vals[i], 1'b0}, 13);
    check("t5_cnt", 32'(cnt_b), 32'd4);
    check("t5_ovr", 32'(ovr_b), 32'd1);
    for (int i = 0; i < 4; i++) pop_check(1'b1, $sformatf("t5_pop%0d", i), vals[i], 1'b0, 1'b0);
    check("t5_empty", 32'(vld_b), 32'd0);
    check("t5_ovr_sticky", 32'(ovr_b), 32'd1);
    clr_b = 1'b1;
    @(posedge clk);
    #1;
    clr_b = 1'b0;
    check("t5_ovr_clr", 32'(ovr_b), 32'd0);

    // T6: pending word plus a partial frame, then asynchronous reset mid-DATA
    send(1'b0, {1'b1, 8'h3C, 1'b0}, 10);
    check("t6_pend", 32'(cnt_a), 32'd1);
    rx_a = 1'b0;
    repeat (3 * 16 * 4) @(posedge clk);
    #1;
    check("t6_busy_mid", 32'(busy_a), 32'd1);
    reset = 1'b1;
    rx_a  = 1'b1;
    #2;
    check("t6_rst_vld",  32'(vld_a),  32'd0);
    check("t6_rst_cnt",  32'(cnt_a),  32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_data", 32'(data_a), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(1'b0, {1'b1, 8'h5A, 1'b0}, 10);
    check("t6_cnt", 32'(cnt_a), 32'd1);
    pop_check(1'b0, "t6", 9'h05A, 1'b0, 1'b0);
    check("t6_empty", 32'(cnt_a), 32'd0);

    // Long break: 20 bit-times low
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
    exp_brk = 1;
`else
    exp_brk = 0;
`endif
    rx_a = 1'b0;
    repeat (20 * 16 * 4) @(posedge clk);
    #1;
    check("brk_cnt",  32'(cnt_a),    32'd1);
    check("brk_busy", 32'(busy_a),   32'(exp_brk));
    check("brk_puls", 32'(brk_seen), 32'(exp_brk));
    rx_a = 1'b1;
    repeat (3 * 64) @(posedge clk);
    #1;
    check("brk_idle", 32'(busy_a), 32'd0);
    check("brk_cnt2", 32'(cnt_a),  32'd1);
    pop_check(1'b0, "brk", 9'h000, 1'b0, 1'b1);
    check("brk_puls2", 32'(brk_seen), 32'(exp_brk));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
